// File: rtl/ship_pkg.sv
// Shared ship sprite ROM geometry: line count, address and line widths.
package ship_pkg;

    localparam int unsigned SHIP_LINES  = 48;
    localparam int unsigned SHIP_ADDR_W = 7;
    localparam int unsigned SHIP_DATA_W = 48;

    typedef logic [SHIP_ADDR_W-1:0] ship_addr_t;
    typedef logic [SHIP_DATA_W-1:0] ship_line_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; priority starts just after the last granted index.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] last_ptr_q;
    logic [PTR_W-1:0] last_ptr_d;
    logic [PTR_W-1:0] win_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr_q <= PTR_W'(N_REQ - 1);
        end else begin
            last_ptr_q <= last_ptr_d;
        end
    end

    // Scan from last_ptr+1 with wrap; the first asserted request wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        win_idx = last_ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = 32'(last_ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found             = 1'b1;
                win_idx           = PTR_W'(idx);
                gnt[PTR_W'(idx)]  = 1'b1;
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_comb begin
        last_ptr_d = last_ptr_q;
        if (advance) begin
            last_ptr_d = win_idx;
        end
    end

endmodule

// File: rtl/ship_rom_arbiter.sv
// Shares one registered ship_rom between N_REQ drawers: grant, address mux,
// range check and a 3-stage tag/valid pipeline returning lines in grant order.
module ship_rom_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_W     = ship_pkg::SHIP_ADDR_W,
    parameter int unsigned DATA_W     = ship_pkg::SHIP_DATA_W,
    parameter int unsigned SHIP_LINES = ship_pkg::SHIP_LINES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err
);

    localparam int unsigned TAG_W = $clog2(N_REQ);

    logic              accept_c;
    logic [ADDR_W-1:0] sel_addr;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_err;

    logic              s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    logic              s1_err_q,   s1_err_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    logic              s2_err_q,   s2_err_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (accept_c),
        .gnt     (gnt)
    );

    assign accept_c = |gnt;

    // Address/tag of the granted requester; grant is one-hot so order is moot.
    always_comb begin
        sel_addr = '0;
        sel_tag  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_tag  = TAG_W'(i);
            end
        end
        sel_err = (32'(sel_addr) >= SHIP_LINES);
    end

    always_comb begin
        s1_valid_d  = accept_c;
        s1_tag_d    = s1_tag_q;
        s1_err_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        if (accept_c) begin
            s1_tag_d   = sel_tag;
            s1_err_d   = sel_err;
            rom_addr_d = sel_err ? '0 : sel_addr;
        end
        s2_valid_d  = s1_valid_q;
        s2_tag_d    = s1_tag_q;
        s2_err_d    = s1_err_q;
        rsp_valid_d = s2_valid_q ? (N_REQ'(1) << s2_tag_q) : '0;
        rsp_data_d  = s2_err_q ? '0 : rom_data;
        rsp_err_d   = s2_valid_q & s2_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_err_q    <= 1'b0;
            rom_addr_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            s2_err_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_err_q    <= s1_err_d;
            rom_addr_q  <= rom_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_tag_q    <= s2_tag_d;
            s2_err_q    <= s2_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ship_rom_arbiter.sv
// Scoreboard bench for ship_rom_arbiter with a 4-requester instance and a
// behavioural registered ROM; expected responses carry their due cycle.
module tb_ship_rom_arbiter;
    import ship_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = SHIP_ADDR_W;
    localparam int unsigned DW = SHIP_DATA_W;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    ship_addr_t      rom_addr;
    ship_line_t      rom_data;
    logic [N-1:0]    rsp_valid;
    ship_line_t      rsp_data;
    logic            rsp_err;

    ship_rom_arbiter #(
        .N_REQ      (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SHIP_LINES (SHIP_LINES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural ship_rom: one registered read per cycle.
    ship_line_t rom_mem [128];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic       err;
        ship_line_t data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_last;
    logic       exp_rom_pend;
    ship_addr_t exp_rom;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first requester found walking forward from last+1.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (last + k) % int'(N);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*AW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    // One clock of stimulus: drive at negedge, check gnt, queue the expected response.
    task automatic cycle(input logic r_rst, input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int         w;
        ship_addr_t ad;
        exp_t       e;
        @(negedge clk);
        if (exp_rom_pend) check("rom_addr", 64'(rom_addr), 64'(exp_rom));
        exp_rom_pend = 1'b0;
        rst      = r_rst;
        req      = r;
        req_addr = a;
        #1;
        if (r_rst) begin
            sb.delete();
            model_last = N - 1;
            check("gnt_in_reset", 64'(gnt), 64'd0);
        end else begin
            w = rr_pick(r, model_last);
            check("gnt", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
            if (w >= 0) begin
                ad         = a[w*AW +: AW];
                e.idx      = w;
                e.err      = (int'(ad) >= int'(SHIP_LINES));
                e.data     = e.err ? '0 : rom_mem[ad];
                e.due      = cyc + 3;
                sb.push_back(e);
                model_last   = w;
                exp_rom_pend = 1'b1;
                exp_rom      = e.err ? '0 : ad;
            end
        end
    endtask

    // Monitor: each due response must be present; anything else is spurious.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
        end else if (rsp_valid !== '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_spurious: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
        end
    end

    function automatic int rand_addr();
        case ($urandom_range(0, 5))
            0:       return 47;
            1:       return 48;
            2:       return int'($urandom_range(48, 127));
            default: return int'($urandom_range(0, 47));
        endcase
    endfunction

    initial begin
        rst          = 1'b1;
        req          = '0;
        req_addr     = '0;
        model_last   = N - 1;
        exp_rom_pend = 1'b0;
        for (int i = 0; i < 128; i++) rom_mem[i] = DW'({$urandom, $urandom});
        rom_mem[0]  = '1;
        rom_mem[5]  = '1;
        rom_mem[23] = '1;
        rom_mem[47] = '1;
        rom_mem[24] = '0;
        rom_mem[30] = '0;

        cycle(1'b1, '0, '0);
        cycle(1'b1, '0, '0);
        cycle(1'b1, '1, pack(1, 2, 3, 4));
        check("reset_rom_addr", 64'(rom_addr), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);

        // Single fetch after reset goes to requester 0.
        cycle(1'b0, 4'b0001, pack(5, 0, 0, 0));
        check("first_gnt_req0", 64'(gnt), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0);

        // Two requesters held: alternating grants, back-to-back responses.
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0011, pack(0, 30, 0, 0));
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0);

        // Full throughput from one requester, including top valid line.
        cycle(1'b0, 4'b0001, pack(23, 0, 0, 0));
        cycle(1'b0, 4'b0001, pack(24, 0, 0, 0));
        cycle(1'b0, 4'b0001, pack(47, 0, 0, 0));
        cycle(1'b0, 4'b0001, pack(48, 0, 0, 0));
        cycle(1'b0, 4'b0001, pack(127, 0, 0, 0));
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0);

        // Reset right behind two acceptances drops both.
        cycle(1'b0, 4'b0001, pack(1, 0, 0, 0));
        cycle(1'b0, 4'b0010, pack(0, 2, 0, 0));
        cycle(1'b1, 4'b0011, pack(3, 4, 0, 0));
        cycle(1'b0, 4'b0011, pack(6, 7, 0, 0));
        check("post_reset_gnt_req0", 64'(gnt), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0);

        // All four requesting from a fresh pointer: strict rotation.
        cycle(1'b1, '0, '0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b1111, pack(i, i + 10, i + 20, i + 50));
            check("rotation_gnt", 64'(gnt), 64'd1 << (i % 4));
        end
        cycle(1'b0, 4'b1111, pack(9, 9, 9, 9));
        check("rotation_wraps_to_req0", 64'(gnt), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0);

        // Randomised traffic with occasional mid-flight reset.
        for (int i = 0; i < 600; i++) begin
            logic r_rst;
            r_rst = ($urandom_range(0, 49) == 0);
            cycle(r_rst, N'($urandom_range(0, 15)),
                  pack(rand_addr(), rand_addr(), rand_addr(), rand_addr()));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ship_rom_arbiter.md
# ship_rom_arbiter

Round-robin arbiter that shares one `ship_rom` instance (7-bit line address in, 48-bit line pixels out, one registered cycle) between several drawing requesters. Typical requesters are the player-board and enemy-board ship drawers in the VGA pipeline. The block accepts at most one line fetch per cycle and forwards the ROM address. It returns the ROM line to the requester that was granted, tagged with a per-requester valid pulse. It sits between the draw modules and `ship_rom` and is fully pipelined.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `ADDR_W`, default 7: ROM line address width.
- `DATA_W`, default 48: ROM line width in pixels.
- `SHIP_LINES`, default 48: number of valid ROM lines (0..47).

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `req`, in, `N_REQ`: fetch request per requester. Level signal, held until granted.
- `req_addr`, in, `N_REQ*ADDR_W`: line address per requester. Requester i uses slice [i*ADDR_W +: ADDR_W].
- `gnt`, out, `N_REQ`: combinational one-hot grant in the acceptance cycle.
- `rom_addr`, out, `ADDR_W`: registered address driven to `ship_rom`.
- `rom_data`, in, `DATA_W`: `ship_rom` registered output.
- `rsp_valid`, out, `N_REQ`: registered one-hot response pulse, one cycle wide.
- `rsp_data`, out, `DATA_W`: registered line data, qualified by `rsp_valid`.
- `rsp_err`, out, 1: registered flag. Asserted with `rsp_valid` when the address was ≥ `SHIP_LINES`.

## Operation
- Each cycle, `gnt` selects at most one asserted `req` in round-robin order.
  - Highest priority is the index after `last_ptr`, wrapping from `N_REQ-1` to 0.
  - `gnt` = 0 when `req` = 0.
  - `gnt` depends only on `req` and `last_ptr`, never on `req_addr`.
- Acceptance occurs in a cycle where `|gnt` = 1. At the next edge:
  - `last_ptr` ← granted index.
  - Stage 1 registers `rom_addr` ← granted address, plus valid, tag (requester index) and err.
  - err = address ≥ `SHIP_LINES`.
  - If err, `rom_addr` ← 0 so `ship_rom` never sees an undecoded address.
- Stage 2 is tag/valid/err delay only, aligned with the `ship_rom` register.
- Output stage: `rsp_data` ← (err ? 0 : `rom_data`); `rsp_valid[tag]` ← valid; `rsp_err` ← valid & err.
- A requester may deassert `req` or change `req_addr` the cycle after it sees `gnt`. Holding `req` requests another fetch.
- A single requester holding `req` continuously is granted every cycle, at full throughput.
- There is no backpressure: a requester must accept `rsp_valid` when it arrives.
- `last_ptr` updates only on acceptance. With no requests the pointer holds.

## Timing
- Acceptance at edge k: `rom_addr` valid after k, ROM data after k+1, `rsp_valid`/`rsp_data` after k+2. Fixed latency 3 edges from the grant cycle.
- Throughput: 1 response per cycle. Responses return in grant order.
- Reset values:
  - `rom_addr` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0.
  - All stage valids = 0.
  - `last_ptr` = `N_REQ-1`, so requester 0 wins first.
  - `gnt` = 0 while `rst` is high.
- Reset mid-operation: all in-flight fetches are dropped and no `rsp_valid` appears for them. Grants resume the cycle after `rst` falls.
- Simultaneous requests from all requesters: strict rotation, one grant per cycle, no requester starved beyond `N_REQ-1` cycles.
- Address `SHIP_LINES-1` (47) is valid. Address 48..127 produces `rsp_err` = 1 and `rsp_data` = 0.

## Structure
- Shared package `ship_pkg` holds the constants `SHIP_LINES` = 48, `SHIP_ADDR_W` = 7 and `SHIP_DATA_W` = 48. It also holds the typedefs `ship_addr_t` and `ship_line_t`.
- Sub-module `rr_arbiter`, parameterised on `N_REQ`, contains the round-robin pointer and the combinational one-hot grant logic. It exposes `req`, `gnt` and an `advance` input.
- The top-level block holds the address mux, error check and 3-stage tag/valid pipeline.

## Test plan
- Reset, then `req`=01 with addr0=5 → `gnt`=01. After 3 edges, `rsp_valid`=01 and `rsp_data`=48'hffffffffffff.
- `req`=11 held 4 cycles, addr0=0, addr1=30 → `gnt` sequence 01,10,01,10. Responses alternate FFFF…/0000… in the same order, back-to-back.
- Single requester, addresses 23, 24, 47 on consecutive cycles → `rsp_data` ffffffffffff, 000000000000, ffffffffffff on consecutive cycles.
- addr0=48 and addr0=127 → `rsp_valid`=01, `rsp_err`=1, `rsp_data`=0, `rom_addr`=0.
- `rst` asserted one cycle after two acceptances → no `rsp_valid` ever. After release, requester 0 is granted first.
- `N_REQ`=4, all requesting for 8 cycles → `gnt` 0001,0010,0100,1000 repeated twice, `last_ptr` ending at 3.
